rr_grant_arbiter: RTL and testbench



---
 rtl/rr_grant_arbiter_if.sv | 26 ++
 rtl/rr_grant_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant/revoke bundle between the requester-side FSMs and the round-robin arbiter.
interface rr_grant_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned OWNER_W = $clog2(N_REQ);

    logic               i_en;
    logic [N_REQ-1:0]   i_req;
    logic [N_REQ-1:0]   i_rel;
    logic [N_REQ-1:0]   o_gnt;
    logic [N_REQ-1:0]   o_revoke;
    logic               o_busy;
    logic [OWNER_W-1:0] o_owner;

    // Requester side drives requests/releases and observes grants.
    modport master (
        output i_en, i_req, i_rel,
        input  o_gnt, o_revoke, o_busy, o_owner
    );

    // Arbiter side.
    modport slave (
        input  i_en, i_req, i_rel,
        output o_gnt, o_revoke, o_busy, o_owner
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with bounded tenure: one grant at a time, holder is asked
// (never forced) to release via revoke once its tenure expires under contention.
module rr_grant_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                i_ck,
    input  logic                i_arst_n,
    rr_grant_arbiter_if.slave   bus
);
    localparam int unsigned OWNER_W = $clog2(N_REQ);
    localparam int unsigned CNT_W   = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_REVOKE = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    state_e             state_q,   state_d;
    logic [OWNER_W-1:0] owner_q,   owner_d;
    logic [OWNER_W-1:0] ptr_q,     ptr_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [N_REQ-1:0]   gnt_q,     gnt_d;
    logic [N_REQ-1:0]   revoke_q,  revoke_d;
    logic               busy_q,    busy_d;
    logic [OWNER_W-1:0] owner_o_q, owner_o_d;

    logic [OWNER_W-1:0] sel_c;
    logic               any_req_c;
    logic [N_REQ-1:0]   owner_oh_c;
    logic               release_c;
    logic               others_c;
    logic               limit_c;
    logic [OWNER_W-1:0] next_ptr_c;

    // First requester at or above the pointer, wrapping past N_REQ-1.
    always_comb begin
        int unsigned idx;
        sel_c     = '0;
        any_req_c = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any_req_c && bus.i_req[idx]) begin
                any_req_c = 1'b1;
                sel_c     = OWNER_W'(idx);
            end
        end
    end

    // Holder-relative conditions; dropping the request counts as a release.
    always_comb begin
        owner_oh_c = N_REQ'(1) << owner_q;
        release_c  = bus.i_rel[owner_q] | ~bus.i_req[owner_q];
        others_c   = |(bus.i_req & ~owner_oh_c);
        limit_c    = (cnt_q >= CNT_W'(HOLD_CYCLES - 1));
        next_ptr_c = (owner_q == OWNER_W'(N_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        revoke_d  = revoke_q;
        busy_d    = busy_q;
        owner_o_d = owner_o_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_en && any_req_c) begin
                    state_d   = ST_GRANT;
                    owner_d   = sel_c;
                    cnt_d     = '0;
                    gnt_d     = N_REQ'(1) << sel_c;
                    revoke_d  = '0;
                    busy_d    = 1'b1;
                    owner_o_d = sel_c;
                end
            end

            ST_GRANT: begin
                if (release_c) begin
                    state_d   = ST_GAP;
                    ptr_d     = next_ptr_c;
                    cnt_d     = '0;
                    gnt_d     = '0;
                    revoke_d  = '0;
                    busy_d    = 1'b0;
                    owner_o_d = '0;
                end else if (limit_c && others_c) begin
                    state_d  = ST_REVOKE;
                    revoke_d = owner_oh_c;
                end else if (cnt_q != CNT_W'(HOLD_CYCLES)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Revoke stands even if the contenders go away; only the holder ends it.
            ST_REVOKE: begin
                if (release_c) begin
                    state_d   = ST_GAP;
                    ptr_d     = next_ptr_c;
                    cnt_d     = '0;
                    gnt_d     = '0;
                    revoke_d  = '0;
                    busy_d    = 1'b0;
                    owner_o_d = '0;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                gnt_d     = '0;
                revoke_d  = '0;
                busy_d    = 1'b0;
                owner_o_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_ck or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            revoke_q  <= '0;
            busy_q    <= 1'b0;
            owner_o_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            revoke_q  <= revoke_d;
            busy_q    <= busy_d;
            owner_o_q <= owner_o_d;
        end
    end

    assign bus.o_gnt    = gnt_q;
    assign bus.o_revoke = revoke_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_owner  = owner_o_q;

    // Output-shape invariants relied on by the downstream client FSMs.
    a_gnt_onehot0 : assert property (@(posedge i_ck) disable iff (!i_arst_n)
        $onehot0(gnt_q));
    a_revoke_match : assert property (@(posedge i_ck) disable iff (!i_arst_n)
        (revoke_q == '0) || (revoke_q == gnt_q));
    a_busy_match : assert property (@(posedge i_ck) disable iff (!i_arst_n)
        busy_q == (|gnt_q));
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed vectors push expected outputs, a negedge monitor checks them.
module tb_rr_grant_arbiter;
    localparam int unsigned N    = 4;
    localparam int unsigned HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    rr_grant_arbiter_if #(.N_REQ(N)) bus ();

    rr_grant_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD)) dut (
        .i_ck     (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] rev;
        logic       busy;
        logic [1:0] owner;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_vec    = 0;
    exp_t mon_e;
    exp_t mon_a;

    // Queue the outputs expected during this cycle, then drive this cycle's inputs.
    task automatic step(input logic en, input logic [3:0] req, input logic [3:0] rel,
                        input logic [3:0] g, input logic [3:0] r);
        exp_t e;
        @(posedge clk);
        #1;
        e.gnt   = g;
        e.rev   = r;
        e.busy  = |g;
        e.owner = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) e.owner = 2'(i);
        end
        exp_q.push_back(e);
        bus.i_en  = en;
        bus.i_req = req;
        bus.i_rel = rel;
    endtask

    // Async reset taken mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.o_gnt !== 4'b0 || bus.o_revoke !== 4'b0 || bus.o_busy !== 1'b0 || bus.o_owner !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b rev=%b busy=%b owner=%0d, want all zero",
                     bus.o_gnt, bus.o_revoke, bus.o_busy, bus.o_owner);
        end
        bus.i_en  = 1'b1;
        bus.i_req = 4'b0;
        bus.i_rel = 4'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_a = {bus.o_gnt, bus.o_revoke, bus.o_busy, bus.o_owner};
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_vec++;
                n_checks++;
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL vector %0d: got gnt=%b rev=%b busy=%b owner=%0d, want gnt=%b rev=%b busy=%b owner=%0d",
                             n_vec, mon_a.gnt, mon_a.rev, mon_a.busy, mon_a.owner,
                             mon_e.gnt, mon_e.rev, mon_e.busy, mon_e.owner);
                end
            end
            n_checks++;
            if (!$onehot0(bus.o_gnt) || (bus.o_revoke != 4'b0 && bus.o_revoke != bus.o_gnt) ||
                bus.o_busy !== (|bus.o_gnt)) begin
                n_fail++;
                $display("FAIL invariant: got gnt=%b rev=%b busy=%b", bus.o_gnt, bus.o_revoke, bus.o_busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_en  = 1'b1;
        bus.i_req = 4'b0;
        bus.i_rel = 4'b0;

        // Single grant and release.
        do_reset();
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        step(1, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        step(1, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        step(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Round robin 0,1,2,3,0 with two dead cycles between grants.
        do_reset();
        step(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g;
            logic [3:0] rq;
            g  = 4'b0001 << (k % 4);
            rq = (k == 4) ? 4'b0000 : 4'b1111;
            step(1, 4'b1111, 4'b0000, g, 4'b0000);
            step(1, 4'b1111, g, g, 4'b0000);
            step(1, rq, 4'b0000, 4'b0000, 4'b0000);
            step(1, rq, 4'b0000, 4'b0000, 4'b0000);
        end

        // Revoke on grant cycle 5, held while contenders drop, then handover.
        do_reset();
        step(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0001);
        step(1, 4'b0001, 4'b0010, 4'b0001, 4'b0001);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0001);
        step(1, 4'b0011, 4'b0001, 4'b0001, 4'b0001);
        step(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0011, 4'b0010, 4'b0010, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // No contention: no revoke; enable low mid-grant has no effect.
        do_reset();
        step(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            step((i < 10) ? 1'b1 : 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        end
        step(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Enable low blocks new grants; pointer at 1 wraps to requester 0; dropping req releases.
        step(0, 4'b0001, 4'b1111, 4'b0000, 4'b0000);
        step(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Release coincides with tenure limit: no revoke pulse, waiting requester next.
        do_reset();
        step(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0000);
        step(1, 4'b0011, 4'b0001, 4'b0001, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0011, 4'b0010, 4'b0010, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset in the middle of REVOKE, then pointer is back at 0.
        do_reset();
        step(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0000);
        end
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0001);
        step(1, 4'b0011, 4'b0000, 4'b0001, 4'b0001);
        do_reset();
        step(1, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b1010, 4'b0000, 4'b0010, 4'b0000);
        step(1, 4'b1010, 4'b0010, 4'b0010, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
